// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The FETCH_BYPASS_EN option lives in fetch_unit.sv.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_REDIRECT,
        S_HALTED
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ~(ADDR_W'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with flush and same-cycle push+pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head reads as zero when empty so the decode-side bus is quiet.
    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    assert property (@(posedge clk) disable iff (rst)
        (push && !pop && !flush) |-> (count_q < CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives ReadPC, buffers responses, hands off to decode.
// Define FETCH_BYPASS_EN to present a response arriving at an empty FIFO combinationally.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   ReadPC,
    input  logic [INSTR_W-1:0]  Instruction,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] readpc_q, readpc_d;
    logic              inflight_q, inflight_d;
    logic              epoch_q, epoch_d;
    logic              issue_epoch_q, issue_epoch_d;

    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      fifo_head;
    fetch_entry_t      resp_entry;
    fetch_entry_t      out_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              resp_valid;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W:0]    limit;
`ifdef FETCH_BYPASS_EN
    logic              bypass_sel;
`endif

    always_comb begin
        resp_valid = inflight_q && (issue_epoch_q == epoch_q);
        resp_entry = '{pc: readpc_q, instr: Instruction};
`ifdef FETCH_BYPASS_EN
        // A response that loses to a redirect is never shown, matching the FIFO path.
        bypass_sel = (fifo_count == '0) && resp_valid && !redirect_valid;
        if_valid   = bypass_sel || (fifo_count != '0);
        out_entry  = bypass_sel ? resp_entry : fifo_head;
        fifo_push  = resp_valid && !redirect_valid && !(bypass_sel && if_ready);
`else
        if_valid   = (fifo_count != '0);
        out_entry  = fifo_head;
        fifo_push  = resp_valid && !redirect_valid;
`endif
        if_pc    = out_entry.pc;
        if_instr = out_entry.instr;
        pop      = if_valid && if_ready;
        fifo_pop = pop && (fifo_count != '0);

        // count + inflight - pop < DEPTH, rearranged to avoid underflow.
        occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
        limit     = (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop);
        issue     = (occupancy < limit) && !redirect_valid &&
                    (((state_q == S_RUN) && !halt) || (state_q == S_REDIRECT));
        ReadPC    = issue ? pc_q : readpc_q;

        state_d       = state_q;
        pc_d          = issue ? (pc_q + PC_STEP) : pc_q;
        readpc_d      = ReadPC;
        inflight_d    = issue;
        epoch_d       = epoch_q;
        issue_epoch_d = issue ? epoch_q : issue_epoch_q;

        case (state_q)
            S_BOOT:     state_d = S_RUN;
            S_RUN: begin
                if (redirect_valid)  state_d = S_REDIRECT;
                else if (halt)       state_d = S_HALTED;
            end
            S_REDIRECT: state_d = redirect_valid ? S_REDIRECT : S_RUN;
            S_HALTED:   if (!halt && !redirect_valid) state_d = S_RUN;
            default:    state_d = S_BOOT;
        endcase

        if (redirect_valid) begin
            epoch_d = ~epoch_q;
            pc_d    = align_pc(redirect_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            readpc_q      <= RESET_PC;
            inflight_q    <= 1'b0;
            epoch_q       <= 1'b0;
            issue_epoch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            readpc_q      <= readpc_d;
            inflight_q    <= inflight_d;
            epoch_q       <= epoch_d;
            issue_epoch_q <= issue_epoch_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .push_data (resp_entry),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a synchronous instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ReadPC;
    logic [31:0] Instruction = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ReadPC         (ReadPC),
        .Instruction    (Instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h2002_0007;
            32'h0000_0008: return 32'h0022_1820;
            32'h0000_000C: return 32'h0800_0000;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) Instruction <= mem_word(ReadPC);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; if_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_cmp++; if (ReadPC !== 32'h0) begin n_bad++; $display("FAIL reset_readpc: got %h want 00000000", ReadPC); end
        n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_if_pc: got %h want 00000000", if_pc); end
        n_cmp++; if (if_instr !== 32'h0) begin n_bad++; $display("FAIL reset_if_instr: got %h want 00000000", if_instr); end
        step();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 0; c < LAT + 4; c++) begin
            settle();
            if (c == 1) begin
                n_cmp++; if (ReadPC !== 32'h0) begin n_bad++; $display("FAIL stream_readpc1: got %h want 00000000", ReadPC); end
            end
            if (c == 2) begin
                n_cmp++; if (ReadPC !== 32'h4) begin n_bad++; $display("FAIL stream_readpc2: got %h want 00000004", ReadPC); end
            end
            n_cmp++;
            if (if_valid !== (c >= LAT)) begin
                n_bad++; $display("FAIL stream_valid c%0d: got %b want %b", c, if_valid, (c >= LAT));
            end
            if (c >= LAT) begin
                exp_pc = 32'(4 * (c - LAT));
                n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL stream_pc c%0d: got %h want %h", c, if_pc, exp_pc); end
                n_cmp++; if (if_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL stream_instr c%0d: got %h want %h", c, if_instr, mem_word(exp_pc)); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 0; c < LAT; c++) step();
        if_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            settle();
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid s%0d: got %b want 1", s, if_valid); end
            n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL stall_pc s%0d: got %h want 00000000", s, if_pc); end
            if (s == 4) begin
                n_cmp++; if (ReadPC !== 32'h4) begin n_bad++; $display("FAIL stall_readpc: got %h want 00000004", ReadPC); end
            end
            step();
        end
        if_ready = 1'b1;
        exp_pc = 32'h0;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (if_valid && if_ready) begin
                n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL resume_pc k%0d: got %h want %h", k, if_pc, exp_pc); end
                n_cmp++; if (if_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL resume_instr k%0d: got %h want %h", k, if_instr, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            step();
        end
        n_cmp++; if (exp_pc !== 32'd40) begin n_bad++; $display("FAIL resume_count: got %0d want 10 transfers", exp_pc / 4); end
    endtask

    task automatic test_redirect();
        int got;
        do_reset();
        for (int c = 0; c < 3; c++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0009;
        settle();
        step();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        settle();
        n_cmp++; if (ReadPC !== 32'h8) begin n_bad++; $display("FAIL redir_readpc: got %h want 00000008", ReadPC); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble: got %b want 0", if_valid); end
        step();
        got = -1;
        for (int c = 5; c < 10 && got < 0; c++) begin
            settle();
            if (if_valid) begin
                got = c;
                n_cmp++; if (if_pc !== 32'h8) begin n_bad++; $display("FAIL redir_pc: got %h want 00000008", if_pc); end
                n_cmp++; if (if_instr !== 32'h0022_1820) begin n_bad++; $display("FAIL redir_instr: got %h want 00221820", if_instr); end
            end
            step();
        end
        n_cmp++; if (got !== 3 + LAT) begin n_bad++; $display("FAIL redir_latency: got cycle %0d want %0d", got, 3 + LAT); end
        settle();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hC) begin n_bad++; $display("FAIL redir_next: got v=%b pc=%h want v=1 pc=0000000c", if_valid, if_pc); end
        step();
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        int n;
        want = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset();
        for (int c = 0; c < 3; c++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            settle();
            if (if_valid && if_ready && n < 3) begin
                n_cmp++; if (if_pc !== want[n]) begin n_bad++; $display("FAIL wrap_pc n%0d: got %h want %h", n, if_pc, want[n]); end
                n_cmp++; if (if_instr !== mem_word(want[n])) begin n_bad++; $display("FAIL wrap_instr n%0d: got %h want %h", n, if_instr, mem_word(want[n])); end
                n++;
            end
            step();
        end
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL wrap_count: got %0d want 3", n); end
    endtask

    task automatic test_halt();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            halt = (c >= 5 && c < 9);
            settle();
            if (c >= 5 && c < 9) begin
                n_cmp++; if (ReadPC !== 32'hC) begin n_bad++; $display("FAIL halt_readpc c%0d: got %h want 0000000c", c, ReadPC); end
            end
            if (if_valid && if_ready) begin
                n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL halt_seq c%0d: got %h want %h", c, if_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
            end
            step();
        end
        halt = 1'b0;
        n_cmp++;
        if (exp_pc !== 32'((4 + 26 - (9 + LAT)) * 4)) begin
            n_bad++; $display("FAIL halt_count: got %0d want %0d transfers", exp_pc / 4, 4 + 26 - (9 + LAT));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_ready = 1'b0;
        for (int c = 0; c < 3; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_ready = 1'b1;
        for (int c = 0; c <= LAT + 1; c++) begin
            settle();
            if (c == 0) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", if_valid); end
                n_cmp++; if (ReadPC !== 32'h0) begin n_bad++; $display("FAIL rstmid_readpc: got %h want 00000000", ReadPC); end
            end
            if (c == LAT) begin
                n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_bad++; $display("FAIL rstmid_first: got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
            end
            if (c == LAT + 1) begin
                n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_bad++; $display("FAIL rstmid_second: got v=%b pc=%h want v=1 pc=00000004", if_valid, if_pc); end
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
